// File: rtl/multicycle_control_fsm.sv
// Moore sequencer for the multi-cycle RV32 datapath: one ALU and one memory port
// are time-shared across fetch, decode, execute, memory and writeback steps.
module multicycle_control_fsm (
  input  logic        clk,
  input  logic        areset,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        status_SF,
  input  logic        mem_ready,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        memRead,
  output logic        memWrite,
  output logic        RegWrite,
  output logic        AdrSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSRC,
  output logic [1:0]  immSRC,
  output logic [2:0]  ALUControl,
  output logic        instr_done,
  output logic        illegal,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  // Registered control word; input-dependent strobes are gated outside it.
  typedef struct packed {
    logic       fetch;
    logic       mem_read;
    logic       mem_write;
    logic       mw_wait;
    logic       reg_write;
    logic       adr_src;
    logic       retire;
    logic       branch;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [1:0] result_src;
    logic [1:0] imm_src;
    logic [2:0] alu_ctl;
  } ctl_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  state_t state_q;
  ctl_t   ctl_q;
  logic   take;
  logic   unused_instr;

  assign unused_instr = ^{instr[31], instr[29:15], instr[11:7], instr[4:0]};

  function automatic logic is_legal(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE) || (op == OP_RTYPE) ||
           (op == OP_ITYPE) || (op == OP_BRANCH);
  endfunction

  function automatic logic [2:0] alu_op(input logic [2:0] f3, input logic b5, input logic b30);
    logic [2:0] r;
    r = 3'b000;
    case (f3)
      3'b000:                                 r = (b5 && b30) ? 3'b010 : 3'b000;
      3'b001, 3'b100, 3'b101, 3'b110, 3'b111: r = f3;
      default:                                r = 3'b000;
    endcase
    return r;
  endfunction

  function automatic state_t next_state(input state_t s, input logic [6:0] op, input logic rdy);
    state_t n;
    n = S_FETCH;
    case (s)
      S_FETCH:    n = rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: n = S_MEMADR;
          OP_RTYPE:          n = S_EXECR;
          OP_ITYPE:          n = S_EXECI;
          OP_BRANCH:         n = S_BRANCH;
          default:           n = S_FETCH;
        endcase
      end
      S_MEMADR:   n = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  n = rdy ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: n = rdy ? S_FETCH : S_MEMWRITE;
      S_EXECR,
      S_EXECI:    n = S_ALUWB;
      default:    n = S_FETCH;
    endcase
    return n;
  endfunction

  function automatic ctl_t ctl_for(input state_t s, input logic [6:0] op,
                                   input logic [2:0] f3, input logic b5, input logic b30);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.fetch      = 1'b1;
        c.mem_read   = 1'b1;
        c.src_b      = 2'b10;
        c.result_src = 2'b10;
      end
      // Branch target is precomputed here so BRANCH only needs the compare.
      S_DECODE: begin
        c.src_a   = 2'b01;
        c.src_b   = 2'b01;
        c.imm_src = 2'b10;
      end
      S_MEMADR: begin
        c.src_a   = 2'b10;
        c.src_b   = 2'b01;
        c.imm_src = (op == OP_STORE) ? 2'b01 : 2'b00;
      end
      S_MEMREAD: begin
        c.mem_read = 1'b1;
        c.adr_src  = 1'b1;
      end
      S_MEMWB: begin
        c.result_src = 2'b01;
        c.reg_write  = 1'b1;
        c.retire     = 1'b1;
      end
      S_MEMWRITE: begin
        c.mem_write = 1'b1;
        c.adr_src   = 1'b1;
        c.mw_wait   = 1'b1;
      end
      S_EXECR: begin
        c.src_a   = 2'b10;
        c.alu_ctl = alu_op(f3, b5, b30);
      end
      S_EXECI: begin
        c.src_a   = 2'b10;
        c.src_b   = 2'b01;
        c.alu_ctl = alu_op(f3, b5, b30);
      end
      S_ALUWB: begin
        c.reg_write = 1'b1;
        c.retire    = 1'b1;
      end
      S_BRANCH: begin
        c.src_a   = 2'b10;
        c.alu_ctl = 3'b010;
        c.retire  = 1'b1;
        c.branch  = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q <= S_FETCH;
      ctl_q   <= ctl_for(S_FETCH, 7'd0, 3'd0, 1'b0, 1'b0);
    end else begin
      state_q <= next_state(state_q, instr[6:0], mem_ready);
      ctl_q   <= ctl_for(next_state(state_q, instr[6:0], mem_ready),
                         instr[6:0], instr[14:12], instr[5], instr[30]);
    end
  end

  always_comb begin
    take = 1'b0;
    case (instr[14:12])
      3'b000:  take = zero;
      3'b001:  take = ~zero;
      3'b100:  take = status_SF;
      default: take = 1'b0;
    endcase
  end

  // Reset forces every strobe and select low without waiting for a clock.
  assign IRWrite    = ~areset & ctl_q.fetch & mem_ready;
  assign PCWrite    = ~areset & ((ctl_q.fetch & mem_ready) | (ctl_q.branch & take));
  assign memRead    = ~areset & ctl_q.mem_read;
  assign memWrite   = ~areset & ctl_q.mem_write;
  assign RegWrite   = ~areset & ctl_q.reg_write;
  assign AdrSrc     = ~areset & ctl_q.adr_src;
  assign ALUSrcA    = areset ? 2'b00 : ctl_q.src_a;
  assign ALUSrcB    = areset ? 2'b00 : ctl_q.src_b;
  assign ResultSRC  = areset ? 2'b00 : ctl_q.result_src;
  assign immSRC     = areset ? 2'b00 : ctl_q.imm_src;
  assign ALUControl = areset ? 3'b000 : ctl_q.alu_ctl;
  assign instr_done = ~areset & (ctl_q.retire | (ctl_q.mw_wait & mem_ready));
  assign illegal    = ~areset & (state_q == S_DECODE) & ~is_legal(instr[6:0]);
  assign state      = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: directed instructions plus random traffic,
// checked cycle by cycle against an instruction-level reference model.
module tb_multicycle_control_fsm;

  logic        clk;
  logic        areset;
  logic [31:0] instr;
  logic        zero;
  logic        status_SF;
  logic        mem_ready;
  logic        IRWrite, PCWrite, memRead, memWrite, RegWrite, AdrSrc;
  logic [1:0]  ALUSrcA, ALUSrcB, ResultSRC, immSRC;
  logic [2:0]  ALUControl;
  logic        instr_done, illegal;
  logic [3:0]  state;

  int errors = 0;
  int checks = 0;

  multicycle_control_fsm dut (
    .clk(clk), .areset(areset), .instr(instr), .zero(zero), .status_SF(status_SF),
    .mem_ready(mem_ready), .IRWrite(IRWrite), .PCWrite(PCWrite), .memRead(memRead),
    .memWrite(memWrite), .RegWrite(RegWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ResultSRC(ResultSRC), .immSRC(immSRC), .ALUControl(ALUControl),
    .instr_done(instr_done), .illegal(illegal), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [22:0] dut_vec;
  assign dut_vec = {state, IRWrite, PCWrite, memRead, memWrite, RegWrite, AdrSrc,
                    ALUSrcA, ALUSrcB, ResultSRC, immSRC, ALUControl, instr_done, illegal};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected outputs for a given step of an instruction, straight from the state table.
  function automatic logic [22:0] exp_vec(input int st, input logic [31:0] ins,
                                          input logic rdy, input logic z, input logic s);
    logic irw, pcw, mrd, mwr, rgw, adr, done, ill;
    logic [1:0] srca, srcb, res, imm;
    logic [2:0] aluc, f3;
    logic [6:0] op;
    logic [3:0] sc;
    irw = 0; pcw = 0; mrd = 0; mwr = 0; rgw = 0; adr = 0; done = 0; ill = 0;
    srca = 0; srcb = 0; res = 0; imm = 0; aluc = 0;
    op = ins[6:0];
    f3 = ins[14:12];
    sc = st[3:0];
    case (st)
      0: begin mrd = 1; srcb = 2'b10; res = 2'b10; irw = rdy; pcw = rdy; end
      1: begin
        srca = 2'b01; srcb = 2'b01; imm = 2'b10;
        ill = !(op == 7'h03 || op == 7'h23 || op == 7'h33 || op == 7'h13 || op == 7'h63);
      end
      2: begin srca = 2'b10; srcb = 2'b01; imm = (op == 7'h23) ? 2'b01 : 2'b00; end
      3: begin mrd = 1; adr = 1; end
      4: begin res = 2'b01; rgw = 1; done = 1; end
      5: begin mwr = 1; adr = 1; done = rdy; end
      6, 7: begin
        srca = 2'b10;
        srcb = (st == 6) ? 2'b00 : 2'b01;
        if (f3 == 3'b000)      aluc = (ins[5] && ins[30]) ? 3'b010 : 3'b000;
        else if (f3 == 3'b010 || f3 == 3'b011) aluc = 3'b000;
        else                   aluc = f3;
      end
      8: begin rgw = 1; done = 1; end
      9: begin
        srca = 2'b10; aluc = 3'b010; done = 1;
        if (f3 == 3'b000)      pcw = z;
        else if (f3 == 3'b001) pcw = !z;
        else if (f3 == 3'b100) pcw = s;
        else                   pcw = 0;
      end
      default: ;
    endcase
    return {sc, irw, pcw, mrd, mwr, rgw, adr, srca, srcb, res, imm, aluc, done, ill};
  endfunction

  // Entered just after a rising edge with the FSM in FETCH; leaves it the same way.
  task automatic run_instr(input logic [31:0] ins, input int wf, input int wm,
                           input int zf, input int sf, output int done_at, output int rd_cycles);
    int q[$];
    logic [6:0] op;
    int st;
    logic rdy;
    op = ins[6:0];
    for (int i = 0; i <= wf; i++) q.push_back(0);
    q.push_back(1);
    case (op)
      7'h03: begin q.push_back(2); for (int i = 0; i <= wm; i++) q.push_back(3); q.push_back(4); end
      7'h23: begin q.push_back(2); for (int i = 0; i <= wm; i++) q.push_back(5); end
      7'h33: begin q.push_back(6); q.push_back(8); end
      7'h13: begin q.push_back(7); q.push_back(8); end
      7'h63: q.push_back(9);
      default: ;
    endcase
    done_at = 0;
    rd_cycles = 0;
    for (int k = 0; k < q.size(); k++) begin
      st = q[k];
      if (st == 0 || st == 3 || st == 5)
        rdy = (k == q.size() - 1) || (q[k+1] != st);
      else
        rdy = ($urandom & 1) != 0;
      mem_ready = rdy;
      instr     = (st == 0) ? $urandom : ins;
      zero      = (zf < 0) ? (($urandom & 1) != 0) : (zf != 0);
      status_SF = (sf < 0) ? (($urandom & 1) != 0) : (sf != 0);
      @(negedge clk);
      check($sformatf("ins%h_step%0d_st%0d", ins, k, st), 32'(dut_vec),
            32'(exp_vec(st, instr, rdy, zero, status_SF)));
      if (instr_done && done_at == 0) done_at = k + 1;
      if (memRead && AdrSrc) rd_cycles++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int d, r, cls;
    logic [31:0] rv, ins;
    areset = 1'b1; instr = 32'd0; zero = 1'b0; status_SF = 1'b0; mem_ready = 1'b1;
    #2;
    check("reset_t0", 32'(dut_vec), 32'd0);
    @(negedge clk);
    check("reset_held", 32'(dut_vec), 32'd0);
    @(posedge clk);
    #1 areset = 1'b0;

    run_instr(32'h002081B3, 0, 0, -1, -1, d, r);
    check("add_latency", 32'(d), 32'd4);
    run_instr(32'h402081B3, 0, 0, -1, -1, d, r);
    run_instr(32'h40008193, 1, 0, -1, -1, d, r);
    run_instr(32'h0000A183, 0, 3, -1, -1, d, r);
    check("lw_latency", 32'(d), 32'd8);
    check("lw_read_hold", 32'(r), 32'd4);
    run_instr(32'h0030A223, 0, 0, -1, -1, d, r);
    check("sw_latency", 32'(d), 32'd4);
    run_instr(32'h00208063, 0, 0, 1, 0, d, r);
    check("beq_latency", 32'(d), 32'd3);
    run_instr(32'h00209063, 0, 0, 1, 0, d, r);
    run_instr(32'h0020C063, 0, 0, 0, 1, d, r);
    run_instr(32'h0020D063, 0, 0, 1, 1, d, r);
    run_instr(32'h0000007F, 0, 0, -1, -1, d, r);
    check("illegal_no_retire", 32'(d), 32'd0);

    // Store stalled in MEMWRITE, then reset asynchronously in mid-cycle.
    ins = 32'h0030A223;
    instr = 32'h0; mem_ready = 1'b1;
    @(negedge clk); check("rst_sw_fetch", 32'(dut_vec), 32'(exp_vec(0, instr, 1'b1, zero, status_SF)));
    @(posedge clk); #1 instr = ins;
    @(negedge clk); check("rst_sw_decode", 32'(dut_vec), 32'(exp_vec(1, ins, 1'b1, zero, status_SF)));
    @(posedge clk); #1;
    @(negedge clk); check("rst_sw_memadr", 32'(dut_vec), 32'(exp_vec(2, ins, 1'b1, zero, status_SF)));
    @(posedge clk); #1 mem_ready = 1'b0;
    @(negedge clk); check("rst_sw_memwrite", 32'(dut_vec), 32'(exp_vec(5, ins, 1'b0, zero, status_SF)));
    #1 areset = 1'b1;
    #1 check("rst_async_all", 32'(dut_vec), 32'd0);
    check("rst_async_memwrite", 32'(memWrite), 32'd0);
    @(posedge clk); #1;
    check("rst_hold_all", 32'(dut_vec), 32'd0);
    areset = 1'b0;
    #1 check("rst_release_memread", 32'(memRead), 32'd1);
    check("rst_release_fetch", 32'(dut_vec), 32'(exp_vec(0, instr, 1'b0, zero, status_SF)));

    for (int n = 0; n < 150; n++) begin
      rv = $urandom;
      cls = $urandom_range(0, 5);
      case (cls)
        0: ins = {rv[31:7], 7'h33};
        1: ins = {rv[31:7], 7'h13};
        2: ins = {rv[31:7], 7'h03};
        3: ins = {rv[31:7], 7'h23};
        4: ins = {rv[31:7], 7'h63};
        default: ins = {rv[31:2], (rv[1:0] == 2'b11) ? 2'b01 : rv[1:0]};
      endcase
      run_instr(ins, $urandom_range(0, 2), $urandom_range(0, 3), -1, -1, d, r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
